trashbin_core_sequencer: RTL and testbench
==========================================

Name: trashbin_core_sequencer

Overview:
Parametrised multi-phase control sequencer for the Trashbin CPU core. It runs fetch, execute, memory and writeback phases with a full ready-style memory handshake for instruction fetch, load and store. It adds branch redirect, halt-on-fault, a wait timeout and a configurable reset vector. It sits between the core datapath (decoder/ALU) and the memory system, and owns the program counter and the bus strobes.

Parameters:
ADDR_W, 32, address bus and program counter width
DATA_W, 32, data bus and instruction width; INSTR_BYTES = DATA_W/8
RESET_VECTOR, 0, PC value after reset; must be INSTR_BYTES-aligned
MEM_TIMEOUT, 0, max cycles waiting for ReadOK/WriteOK; 0 = wait forever

Ports:
CoreClock  in  1  core clock, all state on rising edge
CoreReset  in  1  synchronous active-high reset
AddressBus  out  ADDR_W  registered memory address
DataReadBus  in  DATA_W  memory read data
DataWriteBus  out  DATA_W  registered store data
ReadAssert  out  1  read request strobe, held until ReadOK
WriteAssert  out  1  write request strobe, held until WriteOK
ReadOK  in  1  read completed, DataReadBus valid this cycle
WriteOK  in  1  write accepted
InstrReg  out  DATA_W  current instruction
InstrValid  out  1  one-cycle pulse when InstrReg is updated
DecodeInvalid  in  1  decoder: InstrReg is illegal
DecodeIsLoad  in  1  decoder: load instruction
DecodeIsStore  in  1  decoder: store instruction
DecodeIsBranch  in  1  decoder: branch/jump instruction
MemAddr  in  ADDR_W  effective address from the ALU
StoreData  in  DATA_W  store operand
BranchTaken  in  1  branch condition true
BranchTarget  in  ADDR_W  branch destination
LoadData  out  DATA_W  registered load result
WritebackEn  out  1  one-cycle register-file write pulse
ProgramCounter  out  ADDR_W  current PC
Phase  out  3  current state encoding
Fault  out  1  sticky halt indicator
FaultCode  out  2  01 invalid instr, 10 mem timeout, 11 misaligned branch
CycleCount  out  32  performance counter (see Optional Feature)
RetireCount  out  32  performance counter (see Optional Feature)

Behaviour:
- Reset: state FETCH; PC=RESET_VECTOR; all strobes, pulses, Fault and FaultCode = 0; AddressBus, DataWriteBus, InstrReg and LoadData = 0.
- State encoding: FETCH=0, FETCH_WAIT=1, EXECUTE=2, MEM_WAIT=3, WRITEBACK=4, HALT=7.
- FETCH: AddressBus<=PC; ReadAssert<=1; next state FETCH_WAIT.
- FETCH_WAIT: when ReadOK=1, InstrReg<=DataReadBus, ReadAssert<=0, InstrValid<=1 for one cycle, next state EXECUTE.
- EXECUTE: sample the decode inputs and latch the load/store/branch flags. Priority: invalid > load > store > other.
  - Invalid: go to HALT with code 01.
  - Load: AddressBus<=MemAddr; ReadAssert<=1; go to MEM_WAIT.
  - Store: AddressBus<=MemAddr; DataWriteBus<=StoreData; WriteAssert<=1; go to MEM_WAIT.
  - Other: go to WRITEBACK.
- MEM_WAIT, load: on ReadOK, LoadData<=DataReadBus, ReadAssert<=0, go to WRITEBACK. WriteOK is ignored.
- MEM_WAIT, store: on WriteOK, WriteAssert<=0, go to WRITEBACK. ReadOK is ignored.
- WRITEBACK:
  - WritebackEn pulses for every instruction except store and not-taken branch.
  - Taken branch: PC<=BranchTarget. If BranchTarget low log2(INSTR_BYTES) bits are nonzero, go to HALT with code 11 and leave PC unchanged.
  - Otherwise PC<=PC+INSTR_BYTES, wrapping modulo 2^ADDR_W.
  - Next state FETCH.
- Latency with single-cycle memory: ALU instruction 4 cycles; load or store 5 cycles.
- Timeout: a wait counter clears on entry to FETCH_WAIT or MEM_WAIT. If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT without an OK, go to HALT with code 10 and drop strobes on the same edge. An OK arriving in the limit cycle wins.
- HALT: all strobes 0, no pulses, Fault=1, PC frozen. Exit only via CoreReset.
- OK inputs seen outside the matching wait state are ignored.
- Reset mid-transaction: strobes deassert on the reset edge; no LoadData or PC update.

Optional Feature:
- Macro TRASHBIN_SEQ_PERF_EN.
- Defined: CycleCount increments every non-reset cycle; RetireCount increments on each WRITEBACK exit to FETCH. Both are 32-bit wrapping counters, cleared by reset, and frozen in HALT.
- Undefined: both outputs are tied to 0 and no counter logic is present.

Test Plan:
1. RESET_VECTOR=0x100, ALU instruction, ReadOK one cycle after ReadAssert -> AddressBus=0x100, InstrValid pulse, WritebackEn at cycle 4, PC=0x104.
2. Load with MemAddr=0x2000, ReadOK after 3 wait cycles carrying 0xDEADBEEF -> ReadAssert high for 3 cycles, LoadData=0xDEADBEEF, WritebackEn pulse, PC+4.
3. Store with MemAddr=0x40, StoreData=0x12345678, WriteOK delayed 2 cycles -> WriteAssert held, DataWriteBus=0x12345678, no WritebackEn.
4. Taken branch to 0x80 -> PC=0x80. Taken branch to 0x82 -> HALT, Fault=1, FaultCode=11, PC unchanged.
5. DecodeInvalid=1 -> HALT with FaultCode=01; no ReadAssert for 20 cycles; CoreReset returns to FETCH at RESET_VECTOR.
6. MEM_TIMEOUT=8 and ReadOK never asserted -> FaultCode=10 after 8 wait cycles. Separately, PC=0xFFFFFFFC with an ALU instruction -> PC=0x00000000.

Source files
------------

// File: rtl/trashbin_core_sequencer.sv
// Fetch/execute/memory/writeback control sequencer for the Trashbin core; owns the PC and bus strobes.
// Optional performance counters are built when TRASHBIN_SEQ_PERF_EN is defined.
module trashbin_core_sequencer #(
    parameter int unsigned          ADDR_W       = 32,
    parameter int unsigned          DATA_W       = 32,
    parameter logic [ADDR_W-1:0]    RESET_VECTOR = '0,
    parameter int unsigned          MEM_TIMEOUT  = 0
) (
    input  logic              CoreClock,
    input  logic              CoreReset,
    output logic [ADDR_W-1:0] AddressBus,
    input  logic [DATA_W-1:0] DataReadBus,
    output logic [DATA_W-1:0] DataWriteBus,
    output logic              ReadAssert,
    output logic              WriteAssert,
    input  logic              ReadOK,
    input  logic              WriteOK,
    output logic [DATA_W-1:0] InstrReg,
    output logic              InstrValid,
    input  logic              DecodeInvalid,
    input  logic              DecodeIsLoad,
    input  logic              DecodeIsStore,
    input  logic              DecodeIsBranch,
    input  logic [ADDR_W-1:0] MemAddr,
    input  logic [DATA_W-1:0] StoreData,
    input  logic              BranchTaken,
    input  logic [ADDR_W-1:0] BranchTarget,
    output logic [DATA_W-1:0] LoadData,
    output logic              WritebackEn,
    output logic [ADDR_W-1:0] ProgramCounter,
    output logic [2:0]        Phase,
    output logic              Fault,
    output logic [1:0]        FaultCode,
    output logic [31:0]       CycleCount,
    output logic [31:0]       RetireCount
);

    localparam int unsigned       InstrBytes = DATA_W / 8;
    localparam logic [ADDR_W-1:0] PcStep     = ADDR_W'(InstrBytes);
    localparam logic [ADDR_W-1:0] AlignMask  = ADDR_W'(InstrBytes - 1);

    typedef enum logic [2:0] {
        StFetch     = 3'd0,
        StFetchWait = 3'd1,
        StExecute   = 3'd2,
        StMemWait   = 3'd3,
        StWriteback = 3'd4,
        StHalt      = 3'd7
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] load_data_q, load_data_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              ivalid_q, ivalid_d;
    logic              wb_q, wb_d;
    logic              fault_q, fault_d;
    logic [1:0]        code_q, code_d;
    logic [31:0]       wait_cnt_q, wait_cnt_d;
    logic              is_load_q, is_load_d;
    logic              is_store_q, is_store_d;
    logic              is_branch_q, is_branch_d;
    logic              timeout_hit;

    // Limit cycle is the MEM_TIMEOUT-th wait cycle; an OK in that cycle is checked first.
    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt_q == 32'(MEM_TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        instr_d     = instr_q;
        load_data_d = load_data_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        ivalid_d    = 1'b0;
        wb_d        = 1'b0;
        fault_d     = fault_q;
        code_d      = code_q;
        wait_cnt_d  = wait_cnt_q;
        is_load_d   = is_load_q;
        is_store_d  = is_store_q;
        is_branch_d = is_branch_q;

        unique case (state_q)
            StFetch: begin
                addr_d     = pc_q;
                rd_d       = 1'b1;
                wait_cnt_d = '0;
                state_d    = StFetchWait;
            end
            StFetchWait: begin
                if (ReadOK) begin
                    instr_d  = DataReadBus;
                    rd_d     = 1'b0;
                    ivalid_d = 1'b1;
                    state_d  = StExecute;
                end else if (timeout_hit) begin
                    rd_d    = 1'b0;
                    fault_d = 1'b1;
                    code_d  = 2'b10;
                    state_d = StHalt;
                end else begin
                    wait_cnt_d = wait_cnt_q + 32'd1;
                end
            end
            StExecute: begin
                is_load_d   = !DecodeInvalid && DecodeIsLoad;
                is_store_d  = !DecodeInvalid && !DecodeIsLoad && DecodeIsStore;
                is_branch_d = !DecodeInvalid && !DecodeIsLoad && !DecodeIsStore && DecodeIsBranch;
                wait_cnt_d  = '0;
                if (DecodeInvalid) begin
                    fault_d = 1'b1;
                    code_d  = 2'b01;
                    state_d = StHalt;
                end else if (DecodeIsLoad) begin
                    addr_d  = MemAddr;
                    rd_d    = 1'b1;
                    state_d = StMemWait;
                end else if (DecodeIsStore) begin
                    addr_d  = MemAddr;
                    wdata_d = StoreData;
                    wr_d    = 1'b1;
                    state_d = StMemWait;
                end else begin
                    state_d = StWriteback;
                end
            end
            StMemWait: begin
                if (is_load_q && ReadOK) begin
                    load_data_d = DataReadBus;
                    rd_d        = 1'b0;
                    state_d     = StWriteback;
                end else if (!is_load_q && WriteOK) begin
                    wr_d    = 1'b0;
                    state_d = StWriteback;
                end else if (timeout_hit) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    fault_d = 1'b1;
                    code_d  = 2'b10;
                    state_d = StHalt;
                end else begin
                    wait_cnt_d = wait_cnt_q + 32'd1;
                end
            end
            StWriteback: begin
                if (is_branch_q && BranchTaken) begin
                    if ((BranchTarget & AlignMask) != '0) begin
                        fault_d = 1'b1;
                        code_d  = 2'b11;
                        state_d = StHalt;
                    end else begin
                        pc_d    = BranchTarget;
                        wb_d    = 1'b1;
                        state_d = StFetch;
                    end
                end else begin
                    pc_d    = pc_q + PcStep;
                    wb_d    = !is_store_q && !is_branch_q;
                    state_d = StFetch;
                end
            end
            StHalt: begin
                rd_d = 1'b0;
                wr_d = 1'b0;
            end
            default: begin
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                state_d = StHalt;
            end
        endcase
    end

    always_ff @(posedge CoreClock) begin
        if (CoreReset) begin
            state_q     <= StFetch;
            pc_q        <= RESET_VECTOR;
            addr_q      <= '0;
            wdata_q     <= '0;
            instr_q     <= '0;
            load_data_q <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            ivalid_q    <= 1'b0;
            wb_q        <= 1'b0;
            fault_q     <= 1'b0;
            code_q      <= 2'b00;
            wait_cnt_q  <= '0;
            is_load_q   <= 1'b0;
            is_store_q  <= 1'b0;
            is_branch_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            instr_q     <= instr_d;
            load_data_q <= load_data_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            ivalid_q    <= ivalid_d;
            wb_q        <= wb_d;
            fault_q     <= fault_d;
            code_q      <= code_d;
            wait_cnt_q  <= wait_cnt_d;
            is_load_q   <= is_load_d;
            is_store_q  <= is_store_d;
            is_branch_q <= is_branch_d;
        end
    end

    assign AddressBus     = addr_q;
    assign DataWriteBus   = wdata_q;
    assign ReadAssert     = rd_q;
    assign WriteAssert    = wr_q;
    assign InstrReg       = instr_q;
    assign InstrValid     = ivalid_q;
    assign LoadData       = load_data_q;
    assign WritebackEn    = wb_q;
    assign ProgramCounter = pc_q;
    assign Phase          = state_q;
    assign Fault          = fault_q;
    assign FaultCode      = code_q;

`ifdef TRASHBIN_SEQ_PERF_EN
    logic [31:0] cycle_q, retire_q;

    always_ff @(posedge CoreClock) begin
        if (CoreReset) begin
            cycle_q  <= '0;
            retire_q <= '0;
        end else if (state_q != StHalt) begin
            cycle_q <= cycle_q + 32'd1;
            if (state_q == StWriteback && state_d == StFetch) begin
                retire_q <= retire_q + 32'd1;
            end
        end
    end

    assign CycleCount  = cycle_q;
    assign RetireCount = retire_q;
`else
    assign CycleCount  = '0;
    assign RetireCount = '0;
`endif

endmodule

// File: tb/tb_trashbin_core_sequencer.sv
// Self-checking bench: directed vector table, hand-written corner sequences and a randomized
// instruction stream checked against an instruction-level reference model.
module tb_trashbin_core_sequencer;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;
    localparam logic [31:0] RV = 32'h0000_0100;

    logic          CoreClock = 1'b0;
    logic          CoreReset = 1'b1;
    logic [AW-1:0] AddressBus;
    logic [DW-1:0] DataReadBus = '0;
    logic [DW-1:0] DataWriteBus;
    logic          ReadAssert, WriteAssert;
    logic          ReadOK = 1'b0, WriteOK = 1'b0;
    logic [DW-1:0] InstrReg;
    logic          InstrValid;
    logic          DecodeInvalid = 1'b0, DecodeIsLoad = 1'b0;
    logic          DecodeIsStore = 1'b0, DecodeIsBranch = 1'b0;
    logic [AW-1:0] MemAddr = '0;
    logic [DW-1:0] StoreData = '0;
    logic          BranchTaken = 1'b0;
    logic [AW-1:0] BranchTarget = '0;
    logic [DW-1:0] LoadData;
    logic          WritebackEn;
    logic [AW-1:0] ProgramCounter;
    logic [2:0]    Phase;
    logic          Fault;
    logic [1:0]    FaultCode;
    logic [31:0]   CycleCount, RetireCount;

    trashbin_core_sequencer #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .RESET_VECTOR (RV),
        .MEM_TIMEOUT  (TO)
    ) dut (
        .CoreClock      (CoreClock),
        .CoreReset      (CoreReset),
        .AddressBus     (AddressBus),
        .DataReadBus    (DataReadBus),
        .DataWriteBus   (DataWriteBus),
        .ReadAssert     (ReadAssert),
        .WriteAssert    (WriteAssert),
        .ReadOK         (ReadOK),
        .WriteOK        (WriteOK),
        .InstrReg       (InstrReg),
        .InstrValid     (InstrValid),
        .DecodeInvalid  (DecodeInvalid),
        .DecodeIsLoad   (DecodeIsLoad),
        .DecodeIsStore  (DecodeIsStore),
        .DecodeIsBranch (DecodeIsBranch),
        .MemAddr        (MemAddr),
        .StoreData      (StoreData),
        .BranchTaken    (BranchTaken),
        .BranchTarget   (BranchTarget),
        .LoadData       (LoadData),
        .WritebackEn    (WritebackEn),
        .ProgramCounter (ProgramCounter),
        .Phase          (Phase),
        .Fault          (Fault),
        .FaultCode      (FaultCode),
        .CycleCount     (CycleCount),
        .RetireCount    (RetireCount)
    );

    always #5 CoreClock = ~CoreClock;

    typedef struct {
        logic        inv, ld, st, br, taken;
        logic [31:0] target, maddr, sdata, rdata, iword;
        int          fdel, mdel;
        logic        exp_wb;
        logic [31:0] exp_pc;
        logic [1:0]  exp_code;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_pc;
    int          m_retire;
    vec_t        tbl[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CoreClock);
        #1;
    endtask

    task automatic do_reset();
        CoreReset = 1'b1;
        ReadOK    = 1'b0;
        WriteOK   = 1'b0;
        tick();
        tick();
        CoreReset = 1'b0;
        m_pc      = RV;
        m_retire  = 0;
    endtask

    task automatic check_reset_state();
        chk("rst_phase", Phase, 0);
        chk("rst_pc", ProgramCounter, RV);
        chk("rst_rd", ReadAssert, 0);
        chk("rst_wr", WriteAssert, 0);
        chk("rst_ivalid", InstrValid, 0);
        chk("rst_wb", WritebackEn, 0);
        chk("rst_fault", Fault, 0);
        chk("rst_code", FaultCode, 0);
        chk("rst_addr", AddressBus, 0);
        chk("rst_wdata", DataWriteBus, 0);
        chk("rst_instr", InstrReg, 0);
        chk("rst_ldata", LoadData, 0);
        chk("rst_cycles", CycleCount, 0);
        chk("rst_retire", RetireCount, 0);
    endtask

    function automatic vec_t mk(input logic inv, ld, st, br, taken, input logic [31:0] target,
                                input logic [31:0] maddr, sdata, rdata, input int fdel, mdel,
                                input logic ewb, input logic [31:0] epc, input logic [1:0] ecode);
        vec_t v;
        v.inv = inv; v.ld = ld; v.st = st; v.br = br; v.taken = taken;
        v.target = target; v.maddr = maddr; v.sdata = sdata; v.rdata = rdata;
        v.iword = $urandom;
        v.fdel = fdel; v.mdel = mdel;
        v.exp_wb = ewb; v.exp_pc = epc; v.exp_code = ecode;
        return v;
    endfunction

    // Instruction-level model: what one instruction does to PC, writeback and fault state.
    function automatic void predict(input vec_t v, input logic [31:0] pc, output logic wb,
                                    output logic [31:0] npc, output logic halt,
                                    output logic [1:0] code);
        logic is_br;
        is_br = !v.ld && !v.st && v.br;
        halt  = 1'b0;
        code  = 2'b00;
        wb    = 1'b0;
        npc   = pc;
        if (v.inv) begin
            halt = 1'b1;
            code = 2'b01;
        end else if (is_br && v.taken && (v.target % 4) != 0) begin
            halt = 1'b1;
            code = 2'b11;
        end else begin
            npc = (is_br && v.taken) ? v.target : pc + 32'd4;
            wb  = v.ld || (!v.st && !(is_br && !v.taken));
        end
    endfunction

    // Runs one instruction from FETCH, playing memory and decoder, checking the bus protocol.
    task automatic do_instr(input vec_t v, input logic [31:0] pc, output logic o_wb,
                            output logic [31:0] o_pc, output logic [2:0] o_ph,
                            output logic [1:0] o_code);
        DecodeInvalid  = v.inv;
        DecodeIsLoad   = v.ld;
        DecodeIsStore  = v.st;
        DecodeIsBranch = v.br;
        BranchTaken    = v.taken;
        BranchTarget   = v.target;
        MemAddr        = v.maddr;
        StoreData      = v.sdata;
        tick();
        chk("fetch_addr", AddressBus, pc);
        chk("fetch_rd", ReadAssert, 1);
        chk("wb_one_cycle", WritebackEn, 0);
        for (int i = 0; i < v.fdel; i++) begin
            tick();
            chk("fetch_rd_hold", ReadAssert, 1);
        end
        ReadOK      = 1'b1;
        DataReadBus = v.iword;
        tick();
        DataReadBus = $urandom;
        chk("instr", InstrReg, v.iword);
        chk("ivalid", InstrValid, 1);
        chk("fetch_rd_drop", ReadAssert, 0);
        WriteOK = 1'b1;  // stray OKs while in EXECUTE must be ignored
        tick();
        ReadOK  = 1'b0;
        WriteOK = 1'b0;
        chk("ivalid_pulse", InstrValid, 0);
        if (!v.inv) begin
            if (v.ld) begin
                chk("ld_addr", AddressBus, v.maddr);
                chk("ld_rd", ReadAssert, 1);
                for (int i = 0; i < v.mdel; i++) begin
                    WriteOK = 1'b1;
                    tick();
                    chk("ld_rd_hold", ReadAssert, 1);
                end
                WriteOK     = 1'b0;
                ReadOK      = 1'b1;
                DataReadBus = v.rdata;
                tick();
                ReadOK = 1'b0;
                chk("ld_data", LoadData, v.rdata);
                chk("ld_rd_drop", ReadAssert, 0);
            end else if (v.st) begin
                chk("st_addr", AddressBus, v.maddr);
                chk("st_data", DataWriteBus, v.sdata);
                chk("st_wr", WriteAssert, 1);
                for (int i = 0; i < v.mdel; i++) begin
                    ReadOK = 1'b1;
                    tick();
                    chk("st_wr_hold", WriteAssert, 1);
                end
                ReadOK  = 1'b0;
                WriteOK = 1'b1;
                tick();
                WriteOK = 1'b0;
                chk("st_wr_drop", WriteAssert, 0);
            end
            chk("wb_phase", Phase, 4);
            tick();
        end
        o_wb   = WritebackEn;
        o_pc   = ProgramCounter;
        o_ph   = Phase;
        o_code = FaultCode;
    endtask

    task automatic run_model(input vec_t v);
        logic        wb, h, o_wb;
        logic [31:0] npc, o_pc;
        logic [1:0]  code, o_code;
        logic [2:0]  o_ph;
        predict(v, m_pc, wb, npc, h, code);
        do_instr(v, m_pc, o_wb, o_pc, o_ph, o_code);
        chk("model_wb", o_wb, wb);
        chk("model_pc", o_pc, npc);
        chk("model_phase", o_ph, h ? 7 : 0);
        chk("model_code", o_code, code);
        m_pc = npc;
        if (!h) m_retire++;
`ifdef TRASHBIN_SEQ_PERF_EN
        chk("model_retire", RetireCount, m_retire);
`endif
        if (h) do_reset();
    endtask

    function automatic vec_t rand_vec();
        vec_t        v;
        int          k;
        logic [31:0] t;
        k = $urandom_range(0, 19);
        t = $urandom;
        v = mk(k == 0, k >= 1 && k <= 4, k >= 5 && k <= 8, k >= 9 && k <= 13,
               1'($urandom_range(0, 1)), t & 32'hFFFF_FFFC, $urandom, $urandom, $urandom,
               $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 32'h0, 2'b00);
        if (v.ld) v.st = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) v.target = v.target | 32'($urandom_range(1, 3));
        return v;
    endfunction

    initial begin
        logic        o_wb;
        logic [31:0] o_pc, held_pc, held_cycles;
        logic [2:0]  o_ph;
        logic [1:0]  o_code;

        do_reset();
        check_reset_state();

        tbl[0] = mk(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 1, 32'h104, 2'b00);
        tbl[1] = mk(0, 1, 0, 0, 0, 32'h0, 32'h2000, 32'h0, 32'hDEADBEEF, 0, 2, 1, 32'h108, 2'b00);
        tbl[2] = mk(0, 0, 1, 0, 0, 32'h0, 32'h40, 32'h12345678, 32'h0, 0, 2, 0, 32'h10C, 2'b00);
        tbl[3] = mk(0, 0, 0, 1, 0, 32'h400, 32'h0, 32'h0, 32'h0, 0, 0, 0, 32'h110, 2'b00);
        tbl[4] = mk(0, 1, 0, 0, 0, 32'h0, 32'h3000, 32'h0, 32'h55AA55AA, 7, 7, 1, 32'h114, 2'b00);
        tbl[5] = mk(0, 0, 0, 1, 1, 32'h80, 32'h0, 32'h0, 32'h0, 0, 0, 1, 32'h80, 2'b00);
        tbl[6] = mk(0, 1, 1, 0, 0, 32'h0, 32'h44, 32'h0, 32'hCAFEF00D, 1, 0, 1, 32'h84, 2'b00);
        tbl[7] = mk(0, 0, 1, 0, 0, 32'h0, 32'h48, 32'hA5A5A5A5, 32'h0, 3, 0, 0, 32'h88, 2'b00);
        tbl[8] = mk(0, 0, 0, 1, 1, 32'h82, 32'h0, 32'h0, 32'h0, 0, 0, 0, 32'h88, 2'b11);

        m_pc = RV;
        foreach (tbl[i]) begin
            do_instr(tbl[i], m_pc, o_wb, o_pc, o_ph, o_code);
            chk($sformatf("tbl%0d_wb", i), o_wb, tbl[i].exp_wb);
            chk($sformatf("tbl%0d_pc", i), o_pc, tbl[i].exp_pc);
            chk($sformatf("tbl%0d_phase", i), o_ph, (tbl[i].exp_code != 0) ? 7 : 0);
            chk($sformatf("tbl%0d_code", i), o_code, tbl[i].exp_code);
            chk($sformatf("tbl%0d_fault", i), Fault, tbl[i].exp_code != 0);
            m_pc = tbl[i].exp_pc;
        end
`ifdef TRASHBIN_SEQ_PERF_EN
        chk("perf_retire", RetireCount, 8);
`else
        chk("perf_retire_tied", RetireCount, 0);
        chk("perf_cycles_tied", CycleCount, 0);
`endif

        // HALT is sticky: OKs are ignored, nothing moves until reset.
        held_pc     = ProgramCounter;
        held_cycles = CycleCount;
        ReadOK      = 1'b1;
        WriteOK     = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("halt_no_rd", ReadAssert | WriteAssert | InstrValid | WritebackEn, 0);
        end
        ReadOK  = 1'b0;
        WriteOK = 1'b0;
        chk("halt_pc_frozen", ProgramCounter, held_pc);
        chk("halt_phase", Phase, 7);
        chk("halt_fault", Fault, 1);
        chk("halt_cycles_frozen", CycleCount, held_cycles);
        do_reset();
        check_reset_state();

        // Invalid outranks load; then 20 idle cycles and reset.
        do_instr(mk(1, 1, 0, 0, 0, 32'h0, 32'h900, 32'h0, 32'h0, 0, 0, 0, 32'h0, 2'b00),
                 m_pc, o_wb, o_pc, o_ph, o_code);
        chk("inv_phase", o_ph, 7);
        chk("inv_code", o_code, 2'b01);
        chk("inv_pc", o_pc, RV);
        chk("inv_no_rd", ReadAssert, 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("inv_idle_rd", ReadAssert, 0);
        end
        do_reset();
        chk("inv_reset_phase", Phase, 0);
        chk("inv_reset_pc", ProgramCounter, RV);
        chk("inv_reset_fault", Fault, 0);

        // Load whose ReadOK never comes: halt with code 10 after TO wait cycles.
        DecodeInvalid = 1'b0; DecodeIsLoad = 1'b1; DecodeIsStore = 1'b0; DecodeIsBranch = 1'b0;
        MemAddr = 32'h500;
        tick();
        ReadOK = 1'b1;
        tick();
        ReadOK = 1'b0;
        tick();
        for (int i = 1; i < TO; i++) begin
            tick();
            chk("to_wait_phase", Phase, 3);
            chk("to_wait_rd", ReadAssert, 1);
        end
        tick();
        chk("to_phase", Phase, 7);
        chk("to_code", FaultCode, 2'b10);
        chk("to_rd_drop", ReadAssert, 0);
        chk("to_fault", Fault, 1);
        do_reset();

        // Reset in the middle of a load: strobe drops, no load data or PC update.
        tick();
        ReadOK = 1'b1;
        tick();
        ReadOK = 1'b0;
        tick();
        chk("mid_rd_before", ReadAssert, 1);
        CoreReset   = 1'b1;
        ReadOK      = 1'b1;
        DataReadBus = 32'h1111_1111;
        tick();
        ReadOK    = 1'b0;
        CoreReset = 1'b0;
        chk("mid_rd_drop", ReadAssert, 0);
        chk("mid_ldata", LoadData, 0);
        chk("mid_pc", ProgramCounter, RV);
        chk("mid_phase", Phase, 0);
        m_pc     = RV;
        m_retire = 0;

        // PC wrap at the top of the address space.
        run_model(mk(0, 0, 0, 1, 1, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 2'b00));
        run_model(mk(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 2'b00));
        chk("wrap_pc", ProgramCounter, 32'h0);

        for (int n = 0; n < 40; n++) begin
            run_model(rand_vec());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
